// File: rtl/adc_seq_pkg.sv
// Shared types and widths for the ADC conversion sequencer.
package adc_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSelect,
      StDiscard,
      StCapture
   } seq_state_e;

   localparam int unsigned AVG_W      = 3;
   localparam int unsigned DISC_CNT_W = 3;

endpackage

// File: rtl/adc_seq_rr_pick.sv
// Combinational round-robin finder: first set mask bit strictly after last_ch, wrapping.
module adc_seq_rr_pick #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   last_ch,
   output logic [CH_W-1:0]   next_ch,
   output logic              found
);

   logic [CH_W-1:0] cand;

   always_comb begin
      next_ch = '0;
      found   = 1'b0;
      cand    = '0;
      // Offset NUM_CH wraps back to last_ch itself, so a lone enabled channel is re-picked.
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(last_ch) + i) % NUM_CH);
         if (!found && mask[cand]) begin
            found   = 1'b1;
            next_ch = cand;
         end
      end
   end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Round-robin scheduler sharing one SAR ADC core across NUM_CH inputs.
// Optional threshold alarms are built only when ADC_SEQ_THRESHOLD_EN is defined.
module adc_conv_sequencer
   import adc_seq_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned MATRIX_BITS = 10,
   parameter int unsigned DISCARD     = 1,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_in,
   input  logic [NUM_CH-1:0]        chan_mask_in,
   input  logic [3*NUM_CH-1:0]      avg_cfg_in,
   input  logic                     conv_finished_strobe_in,
   input  logic [MATRIX_BITS-1:0]   result_in,
   output logic [CH_W-1:0]          chan_sel_out,
   output logic [2:0]               avg_control_out,
   output logic                     busy_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [MATRIX_BITS-1:0]   out_data,
   output logic [CH_W-1:0]          out_chan,
   output logic                     overrun_out,
   input  logic [MATRIX_BITS-1:0]   thresh_in,
   input  logic [NUM_CH-1:0]        alarm_clear_in,
   output logic [NUM_CH-1:0]        alarm_out
);

   seq_state_e             state_q, state_d;
   logic [CH_W-1:0]        last_ch_q, last_ch_d;
   logic [CH_W-1:0]        chan_sel_q, chan_sel_d;
   logic [AVG_W-1:0]       avg_q, avg_d;
   logic [DISC_CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
   logic                   capture;

   logic [CH_W-1:0]        pick_ch;
   logic                   pick_found;
   logic [AVG_W-1:0]       pick_avg;

   logic                   out_valid_q, out_valid_d;
   logic [MATRIX_BITS-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]        out_chan_q, out_chan_d;
   logic                   overrun_q, overrun_d;

   adc_seq_rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_pick (
      .mask    (chan_mask_in),
      .last_ch (last_ch_q),
      .next_ch (pick_ch),
      .found   (pick_found)
   );

   always_comb begin
      pick_avg = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick_ch == CH_W'(i)) pick_avg = avg_cfg_in[AVG_W*i +: AVG_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      last_ch_d  = last_ch_q;
      chan_sel_d = chan_sel_q;
      avg_d      = avg_q;
      disc_cnt_d = disc_cnt_q;
      capture    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable_in && |chan_mask_in) state_d = StSelect;
         end
         StSelect: begin
            if (!enable_in || !pick_found) begin
               state_d = StIdle;
            end else begin
               chan_sel_d = pick_ch;
               avg_d      = pick_avg;
               last_ch_d  = pick_ch;
               disc_cnt_d = DISC_CNT_W'(DISCARD);
               state_d    = StDiscard;
            end
         end
         StDiscard: begin
            if (!enable_in) begin
               state_d = StIdle;
            end else if (conv_finished_strobe_in) begin
               disc_cnt_d = disc_cnt_q - 1'b1;
               // The last discarded conversion was still sampled with the old mux/avg settings.
               if (disc_cnt_q == DISC_CNT_W'(1)) state_d = StCapture;
            end
         end
         StCapture: begin
            if (!enable_in) begin
               state_d = StIdle;
            end else if (conv_finished_strobe_in) begin
               capture = 1'b1;
               state_d = StSelect;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      overrun_d   = 1'b0;
      if (capture) begin
         if (out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_data_d  = result_in;
            out_chan_d  = chan_sel_q;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         last_ch_q   <= CH_W'(NUM_CH - 1);
         chan_sel_q  <= '0;
         avg_q       <= '0;
         disc_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_ch_q   <= last_ch_d;
         chan_sel_q  <= chan_sel_d;
         avg_q       <= avg_d;
         disc_cnt_q  <= disc_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         overrun_q   <= overrun_d;
      end
   end

   assign chan_sel_out    = chan_sel_q;
   assign avg_control_out = avg_q;
   assign busy_out        = (state_q != StIdle);
   assign out_valid       = out_valid_q;
   assign out_data        = out_data_q;
   assign out_chan        = out_chan_q;
   assign overrun_out     = overrun_q;

`ifdef ADC_SEQ_THRESHOLD_EN
   logic [NUM_CH-1:0] alarm_q, alarm_d;

   // Set wins over clear; a dropped (overrun) capture still raises its alarm.
   always_comb begin
      alarm_d = alarm_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (capture && chan_sel_q == CH_W'(i) && result_in >= thresh_in) begin
            alarm_d[i] = 1'b1;
         end else if (alarm_clear_in[i]) begin
            alarm_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alarm_q <= '0;
      else        alarm_q <= alarm_d;
   end

   assign alarm_out = alarm_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^{thresh_in, alarm_clear_in};
   assign alarm_out     = '0;
`endif

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Randomized self-checking bench: event-level reference model plus directed literal checks.
module tb_adc_conv_sequencer;

   localparam int NUM_CH  = 4;
   localparam int CH_W    = 2;
   localparam int MB      = 10;
   localparam int DISCARD = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              en = 1'b0;
   logic [3:0]        mask = '0;
   logic [11:0]       avg_cfg = '0;
   logic              strobe = 1'b0;
   logic [MB-1:0]     result = '0;
   logic              ready = 1'b0;
   logic [MB-1:0]     thresh = '0;
   logic [3:0]        aclr = '0;

   logic [CH_W-1:0]   chan_sel;
   logic [2:0]        avg;
   logic              busy;
   logic              o_valid;
   logic [MB-1:0]     o_data;
   logic [CH_W-1:0]   o_chan;
   logic              ovr;
   logic [3:0]        alarm;

   adc_conv_sequencer #(
      .NUM_CH      (NUM_CH),
      .MATRIX_BITS (MB),
      .DISCARD     (DISCARD)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .enable_in               (en),
      .chan_mask_in            (mask),
      .avg_cfg_in              (avg_cfg),
      .conv_finished_strobe_in (strobe),
      .result_in               (result),
      .chan_sel_out            (chan_sel),
      .avg_control_out         (avg),
      .busy_out                (busy),
      .out_valid               (o_valid),
      .out_ready               (ready),
      .out_data                (o_data),
      .out_chan                (o_chan),
      .overrun_out             (ovr),
      .thresh_in               (thresh),
      .alarm_clear_in          (aclr),
      .alarm_out               (alarm)
   );

   int n_cmp = 0;
   int n_err = 0;
   int ovr_cnt = 0;
   int dut_ch_q[$], dut_d_q[$], mod_ch_q[$], mod_d_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: a visit is "pick a channel, then wait DISCARD+1 strobes, keep the last one".
   int         m_phase;  // 0 idle, 1 choosing a channel, 2 visiting
   int         m_left;   // strobes still needed before the captured one arrives
   int         m_last;
   int         m_sel;
   logic [2:0] m_avg;
   logic       m_valid;
   int         m_data;
   int         m_chan;
   logic       m_ovr;
   logic [3:0] m_alarm;

   function automatic int find_next(input logic [3:0] m, input int last);
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx = (last + k) % NUM_CH;
         if (((m >> idx) & 4'd1) != 4'd0) return idx;
      end
      return -1;
   endfunction

   initial begin
      logic        cap;
      logic [11:0] sh;
      logic [3:0]  setv;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_left = 0; m_last = NUM_CH - 1; m_sel = 0; m_avg = '0;
            m_valid = 1'b0; m_data = 0; m_chan = 0; m_ovr = 1'b0; m_alarm = '0;
         end else begin
            cap   = 1'b0;
            m_ovr = 1'b0;
            setv  = '0;
            if (m_phase == 0) begin
               if (en && mask != 4'd0) m_phase = 1;
            end else if (m_phase == 1) begin
               if (!en || find_next(mask, m_last) < 0) begin
                  m_phase = 0;
               end else begin
                  m_sel  = find_next(mask, m_last);
                  sh     = avg_cfg >> (3 * m_sel);
                  m_avg  = sh[2:0];
                  m_last = m_sel;
                  m_left = DISCARD + 1;
                  m_phase = 2;
               end
            end else begin
               if (!en) begin
                  m_phase = 0;
               end else if (strobe) begin
                  m_left--;
                  if (m_left == 0) begin
                     cap = 1'b1;
                     m_phase = 1;
                  end
               end
            end
            if (cap) begin
`ifdef ADC_SEQ_THRESHOLD_EN
               if (result >= thresh) setv = 4'd1 << m_sel;
`endif
               if (m_valid && !ready) begin
                  m_ovr = 1'b1;
               end else begin
                  m_valid = 1'b1;
                  m_data  = int'(result);
                  m_chan  = m_sel;
                  mod_ch_q.push_back(m_sel);
                  mod_d_q.push_back(int'(result));
               end
            end else if (m_valid && ready) begin
               m_valid = 1'b0;
            end
`ifdef ADC_SEQ_THRESHOLD_EN
            m_alarm = (m_alarm & ~aclr) | setv;
`endif
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("chan_sel", 32'(chan_sel), 32'(m_sel));
            chk("avg_control", 32'(avg), 32'(m_avg));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("out_valid", 32'(o_valid), 32'(m_valid));
            chk("out_data", 32'(o_data), 32'(m_data));
            chk("out_chan", 32'(o_chan), 32'(m_chan));
            chk("overrun", 32'(ovr), 32'(m_ovr));
            chk("alarm", 32'(alarm), 32'(m_alarm));
            if (o_valid && ready) begin
               dut_ch_q.push_back(int'(o_chan));
               dut_d_q.push_back(int'(o_data));
            end
            if (ovr) ovr_cnt++;
         end
      end
   end

   initial begin
      int exp_ch[4];
      int exp_d[4];
      exp_ch = '{0, 1, 3, 0};
      exp_d  = '{103, 106, 109, 112};

      // Reset values
      tick();
      chk("rst_chan_sel", 32'(chan_sel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_valid", 32'(o_valid), 0);
      tick();
      rst_n = 1'b1;

      // Round-robin over mask 1011 with continuous strobes
      mask = 4'b1011; avg_cfg = 12'b110_001_011_101; ready = 1'b1; en = 1'b1; strobe = 1'b1;
      for (int n = 0; n < 15; n++) begin
         result = 10'(100 + n);
         tick();
         if (n == 4) begin
            chk("sel_ch1", 32'(chan_sel), 1);
            chk("avg_ch1", 32'(avg), 3);
         end
         if (n == 6) chk("avg_hold_ch1", 32'(avg), 3);
         if (n == 7) chk("avg_ch3", 32'(avg), 6);
      end
      en = 1'b0; strobe = 1'b0;
      tick(); tick();
      chk("rr_dut_count", dut_ch_q.size(), 4);
      chk("rr_model_count", mod_ch_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < dut_ch_q.size()) begin
            chk("rr_dut_chan", dut_ch_q[i], exp_ch[i]);
            chk("rr_dut_data", dut_d_q[i], exp_d[i]);
         end
         if (i < mod_ch_q.size()) begin
            chk("rr_model_chan", mod_ch_q[i], exp_ch[i]);
            chk("rr_model_data", mod_d_q[i], exp_d[i]);
         end
      end

      // Backpressure: overrun retains old data; capture coincident with accept loads new data
      ovr_cnt = 0; ready = 1'b0; en = 1'b1; strobe = 1'b1;
      for (int n = 0; n < 11; n++) begin
         ready  = (n >= 9);
         result = 10'(200 + n);
         tick();
         if (n == 6) begin
            chk("ovr_pulse", 32'(ovr), 1);
            chk("ovr_keep_data", 32'(o_data), 203);
            chk("ovr_keep_chan", 32'(o_chan), 3);
         end
         if (n == 9) begin
            chk("accept_cap_data", 32'(o_data), 209);
            chk("accept_cap_chan", 32'(o_chan), 1);
            chk("accept_cap_valid", 32'(o_valid), 1);
            chk("accept_cap_no_ovr", 32'(ovr), 0);
         end
      end
      en = 1'b0; strobe = 1'b0;
      tick(); tick();
      chk("ovr_pulse_count", ovr_cnt, 1);

      // Enable dropped during discard, then resume after last_ch (3 -> 0 -> 1)
      en = 1'b1;
      tick(); tick(); tick();
      chk("disc_busy", 32'(busy), 1);
      chk("disc_chan", 32'(chan_sel), 0);
      en = 1'b0;
      tick();
      chk("drop_busy", 32'(busy), 0);
      chk("drop_valid", 32'(o_valid), 0);
      en = 1'b1;
      tick(); tick();
      chk("resume_chan", 32'(chan_sel), 1);

      // Asynchronous reset while waiting in capture
      strobe = 1'b1; tick();
      strobe = 1'b0; tick();
      chk("cap_busy", 32'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_chan_sel", 32'(chan_sel), 0);
      chk("arst_avg", 32'(avg), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_valid", 32'(o_valid), 0);
      tick(); tick();
      rst_n = 1'b1;
      mask = 4'b1100;
      tick(); tick();
      chk("post_rst_chan", 32'(chan_sel), 2);
      chk("post_rst_avg", 32'(avg), 1);
      en = 1'b0;
      tick(); tick();

`ifdef ADC_SEQ_THRESHOLD_EN
      mask = 4'b0100; thresh = 10'd600; result = 10'd600; ready = 1'b1; en = 1'b1; strobe = 1'b1;
      repeat (6) tick();
      chk("alarm_at_thresh", 32'(alarm[2]), 1);
      result = 10'd599;
      repeat (4) tick();
      chk("alarm_sticky", 32'(alarm[2]), 1);
      aclr = 4'b0100; tick();
      aclr = 4'b0000;
      repeat (6) tick();
      chk("alarm_below_thresh", 32'(alarm[2]), 0);
      en = 1'b0; strobe = 1'b0;
      tick(); tick();
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en     = ($urandom_range(0, 19) != 0);
         mask   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         strobe = en ? 1'($urandom) : 1'b0;
         result = 10'($urandom);
         ready  = ($urandom_range(0, 3) != 0);
         thresh = 10'($urandom);
         aclr   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
         if ($urandom_range(0, 49) == 0) avg_cfg = 12'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
